// File: rtl/imem_image_loader.sv
// imem_image_loader: assembles byte-stream load records into 16-bit instruction memory writes
// Ports: clk, rst (synchronous, active-high); in_data/in_valid/in_ready byte stream sink;
//        mem_wr/mem_addr/mem_data single-cycle memory write port; busy (record in progress),
//        done (one-cycle record-complete pulse), err (sticky, cleared only by rst).
// Record: addr hi, addr lo, count hi, count lo, then count x (data hi, data lo), big-endian.
// Define LOADER_CKSUM_EN to require a trailer byte that makes the 8-bit sum of the record zero.
module imem_image_loader #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [3:0] {
        A_HI, A_LO, N_HI, N_LO, D_HI, D_LO, WR, ERR
`ifdef LOADER_CKSUM_EN
        , CK
`endif
    } state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [15:0]           cnt_q, cnt_d, mem_data_q, mem_data_d;
    logic [7:0]            hi_q, hi_d;
    logic                  mem_wr_q, mem_wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  xfer, last;
`ifdef LOADER_CKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif
    assign in_ready = !(state_q inside {WR, ERR});
    assign xfer     = in_valid && in_ready;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wr_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        last       = 1'b0;
`ifdef LOADER_CKSUM_EN
        // running sum restarts with the first header byte of each record
        sum_d      = xfer ? ((state_q == A_HI) ? in_data : sum_q + in_data) : sum_q;
`endif
        case (state_q)
            A_HI: if (xfer) begin
                hi_d    = in_data;
                state_d = A_LO;
            end
            A_LO: if (xfer) begin
                addr_d  = ADDR_WIDTH'({hi_q, in_data});
                err_d   = in_data[0];
                state_d = in_data[0] ? ERR : N_HI;
            end
            N_HI: if (xfer) begin
                hi_d    = in_data;
                state_d = N_LO;
            end
            N_LO: if (xfer) begin
                cnt_d   = {hi_q, in_data};
                last    = ({hi_q, in_data} == 16'd0);
                state_d = D_HI;
            end
            D_HI: if (xfer) begin
                hi_d    = in_data;
                state_d = D_LO;
            end
            D_LO: if (xfer) begin
                // output registers load here so the strobe lines up with the WR cycle
                mem_wr_d   = 1'b1;
                mem_addr_d = addr_q;
                mem_data_d = {hi_q, in_data};
                state_d    = WR;
            end
            WR: begin
                addr_d  = addr_q + ADDR_WIDTH'(2);
                cnt_d   = cnt_q - 16'd1;
                last    = (cnt_q == 16'd1);
                state_d = D_HI;
            end
`ifdef LOADER_CKSUM_EN
            CK: if (xfer) begin
                done_d  = (sum_q + in_data) == 8'h00;
                err_d   = (sum_q + in_data) != 8'h00;
                state_d = ((sum_q + in_data) == 8'h00) ? A_HI : ERR;
            end
`endif
            default: ;
        endcase
        if (last) begin
`ifdef LOADER_CKSUM_EN
            state_d = CK;
`else
            state_d = A_HI;
            done_d  = 1'b1;
`endif
        end
        busy_d = !(state_d inside {A_HI, ERR});
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= A_HI;
            addr_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wr_q   <= mem_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end
endmodule

// File: doc/imem_image_loader.md
Name: imem_image_loader

Overview:
- Writer-side companion to the instruction memory. It accepts a byte stream of load records over a valid/ready handshake, assembles big-endian 16-bit words, and drives a single-cycle memory write port.
- Lets benches and boot logic place a program image at runtime, in place of the file load at reset.
- Sits between a host byte source (testbench, UART receiver) and the memory write port.

Parameters:
ADDR_WIDTH, 16, byte-address width of the memory write port.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid this cycle
in_ready  output  1  loader accepts a byte this cycle (combinational from state only)
mem_wr  output  1  one-cycle write strobe to memory
mem_addr  output  ADDR_WIDTH  byte address of the write; bit 0 always 0
mem_data  output  16  write data
busy  output  1  a record is in progress
done  output  1  one-cycle pulse when a record completes
err  output  1  sticky error flag

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Byte transfer: a byte transfers on a rising edge where in_valid && in_ready. in_ready never depends on in_valid.
- Record format, in order:
  - start address hi, start address lo (byte address)
  - count hi, count lo (16-bit word count)
  - count x (data hi, data lo)
- States: A_HI, A_LO, N_HI, N_LO, D_HI, D_LO, WR, ERR.
- in_ready:
  - = 1 in A_HI, A_LO, N_HI, N_LO, D_HI, D_LO.
  - = 0 in WR and ERR.
- Header states: A_HI -> A_LO -> N_HI -> N_LO; each advances on a transfer and latches its byte.
- Leaving A_LO:
  - If the assembled address has bit0 = 1: set err and go to ERR.
  - Otherwise go to N_HI.
- Leaving N_LO:
  - count == 0: pulse done, return to A_HI.
  - count != 0: go to D_HI.
- D_HI -> D_LO: latch the high data byte.
- D_LO -> WR: latch the low data byte.
- WR (exactly one cycle):
  - mem_wr = 1, mem_addr = current address, mem_data = {hi, lo}.
  - Next edge: address += 2 (mod 2^ADDR_WIDTH, silent wrap), remaining -= 1.
  - remaining now 0: pulse done, go to A_HI. Otherwise go to D_HI.
- Timing:
  - mem_wr asserts the cycle after the D_LO byte transfers.
  - Peak throughput is 1 word per 3 cycles.
- mem_wr = 0 in every state except WR. mem_addr and mem_data hold their last values outside WR.
- busy = 1 in every state except A_HI and ERR.
- done is registered: high for one cycle, the cycle after the final WR or after N_LO with count 0. Back-to-back records are allowed.
- ERR: absorbing state; in_ready = 0 and err = 1 until rst.
- Reset values:
  - state A_HI, so in_ready = 1 in the first cycle after reset.
  - mem_wr 0, mem_addr 0, mem_data 0, busy 0, done 0, err 0.
  - Internal address, count and byte latches 0.
- Reset mid-record: the partial record is discarded. No write is issued for a half-assembled word, and the loader restarts at A_HI.
- rst has priority over every transfer and write in the same cycle.

Optional Feature:
LOADER_CKSUM_EN
- Defined:
  - Each record ends with one trailer byte, accepted in an added state CK (in_ready = 1) entered instead of returning to A_HI.
  - Valid trailer: the 8-bit sum of all header, data and trailer bytes equals 0x00 mod 256.
  - Match: pulse done, go to A_HI.
  - Mismatch: set err, go to ERR, no done pulse.
  - Data words are still written as received, before the check.
- Undefined: no trailer byte and no CK state. A record completes as described above.

Test Plan:
- Reset, then stream 00 10 00 02 12 34 AB CD with in_valid held high -> mem_wr at 0x0010 data 0x1234, mem_wr at 0x0012 data 0xABCD; done pulses once after the second write; busy 0 afterwards.
- Stream 00 11 ... (odd address) -> err = 1 and in_ready = 0 after the A_LO transfer; no mem_wr; rst then clears both and in_ready = 1.
- Stream FF FE 00 02 11 11 22 22 -> writes at 0xFFFE and 0x0000 (wrap); done pulses; err stays 0.
- Header 00 20 00 00 -> done pulses the cycle after the fourth byte, no mem_wr; immediately stream 00 30 00 01 BE EF -> write at 0x0030 data 0xBEEF.
- Random in_valid gaps across a 3-word record, plus rst asserted after the D_HI byte of word 2 -> word 1 only written; after reset, a fresh record loads correctly.
- LOADER_CKSUM_EN defined:
  - 00 10 00 01 AB CD 77 -> write at 0x0010 data 0xABCD, done pulses, err 0.
  - Same record with trailer 0x78 -> write occurs, err = 1, no done pulse.
